spi_sram_target: RTL and testbench
==================================

// Module: spi_sram_target
// PURPOSE
//  SPI mode-0 responder that emulates a 23-series serial SRAM: decodes READ (0x03) / WRITE (0x02) + 24-bit address
//  frames from an external SPI host and turns each data byte into a classic Wishbone single transfer on an on-chip bus.
//  Counterpart of our SPI SRAM controller; used for FPGA bring-up and for closed-loop tests of the host side.
//  All SPI inputs are oversampled in the clk_i domain; no logic is clocked by sck.
// PARAMETERS
//  ADDR_WIDTH   23  Wishbone address width; SPI address bits above ADDR_WIDTH-1 are ignored.
//  SYNC_STAGES  2   flip-flop stages on sck, mosi, ss_n before edge detection (>=2).
// PORTS
//  clk_i      in   1           system clock; must be >= 2*(SYNC_STAGES+4) times the sck frequency
//  rst_ni     in   1           asynchronous, active-low reset
//  sck        in   1           SPI clock from host (idle low)
//  mosi       in   1           host-to-target data, sampled on sck rising edge
//  ss_n       in   1           active-low frame select
//  miso       out  1           target-to-host data, changed on sck falling edge
//  miso_oe_o  out  1           pad output enable for miso; 1 while ss_n (synchronised) low
//  cyc_o      out  1           Wishbone cycle
//  stb_o      out  1           Wishbone strobe
//  we_o       out  1           Wishbone write enable
//  adr_o      out  ADDR_WIDTH  Wishbone byte address
//  dat_o      out  8           Wishbone write data
//  dat_i      in   8           Wishbone read data
//  ack_i      in   1           Wishbone acknowledge
//  overrun_o  out  1           sticky: a byte completed while the previous bus transfer was still pending
// BEHAVIOUR
//  Reset: miso=0, miso_oe_o=0, cyc_o=stb_o=we_o=0, adr_o=0, dat_o=0, overrun_o=0; frame FSM IDLE, bus FSM BUS_IDLE.
//  Edge detect on synchronised signals: rise/fall of sck, fall/rise of ss_n; events are single-cycle pulses.
//  Frame FSM: IDLE -(ss_n fall)-> CMD. CMD: shift 8 bits MSB-first; 0x03->ADDR(rd), 0x02->ADDR(wr), other->IGNORE.
//  ADDR: shift 24 bits MSB-first, then ->RDATA or WDATA. IGNORE: miso held 0, no bus activity.
//  Any state -(ss_n rise)-> IDLE; partial command/address/data bytes are discarded; miso_oe_o drops same cycle.
//  ss_n fall clears overrun_o and the bit counter.
//  WDATA: every 8th sampled bit launches a write at the current address, then address+1 (wraps mod 2^ADDR_WIDTH).
//  RDATA: on address completion launch a read; on ack_i load dat_i into the tx shifter and present bit 7 on miso
//   immediately; following bits change on each sck fall. After bit 0 is shifted out, address+1 and next read is
//   launched (prefetch), so sequential reads stream indefinitely while ss_n stays low.
//  Bus FSM: BUS_IDLE -(request)-> BUS_REQ: cyc_o=stb_o=1, adr_o/we_o/dat_o stable until ack_i; ack_i -> BUS_IDLE the
//   next cycle (one transfer per request, no pipelining). err/rty not supported.
//  A request arriving while BUS_REQ is active is dropped and sets overrun_o. ss_n rise never aborts an active bus
//   transfer: it completes normally; read data from it is discarded.
//  Read data not yet acked at the first sck fall of a byte: miso drives 0 for that bit, overrun_o set.
//  Reset assertion mid-frame or mid-transfer: all outputs return to reset values immediately (cyc_o drops async).
// STRUCTURE
//  Package spi_sram_target_pkg: CMD_READ=8'h03, CMD_WRITE=8'h02, frame_state_t {IDLE,CMD,ADDR,RDATA,WDATA,IGNORE},
//   bus_state_t {BUS_IDLE,BUS_REQ}.
//  Sub-module spi_input_sync: SYNC_STAGES synchroniser + rise/fall pulse outputs, instantiated for sck, ss_n, mosi.
//  Frame FSM, bit counter, rx/tx shifters and bus FSM live in this module.
// TESTING
//  Write frame 02 00 01 20 A5 at sck=clk/16 -> one WB write adr_o=0x000120, dat_o=0xA5, we_o=1; overrun_o=0.
//  Burst write 02 00 00 FF 11 22 33 -> writes 0x11@0xFF, 0x22@0x100, 0x33@0x101, in order, one cycle each.
//  Read 03 00 00 10 + 2 dummy bytes, memory model 0x10=0x3C, 0x11=0xC3, ack latency 1 -> miso bytes 0x3C, 0xC3.
//  Address 0x7FFFFF burst write of 2 bytes (ADDR_WIDTH=23) -> second write at adr_o=0x000000 (wrap).
//  Command 0x9F + 4 bytes -> no cyc_o, miso=0 throughout; then ss_n high and valid write frame works.
//  ss_n rise after 4 data bits of write -> no WB write; rst_ni low during BUS_REQ -> cyc_o=0 same cycle.

Source files
------------

// File: rtl/spi_sram_target_pkg.sv
// Shared command codes and state encodings for the SPI serial-SRAM responder.
package spi_sram_target_pkg;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    RDATA,
    WDATA,
    IGNORE
  } frame_state_t;

  typedef enum logic {
    BUS_IDLE,
    BUS_REQ
  } bus_state_t;

endpackage

// File: rtl/spi_input_sync.sv
// Multi-stage synchroniser for one SPI pin, with single-cycle rise/fall pulses
// derived from the synchronised level.
module spi_input_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q_o    = sync_q[SYNC_STAGES-1];
  assign rise_o = q_o & ~prev_q;
  assign fall_o = ~q_o & prev_q;

endmodule

// File: rtl/spi_sram_target.sv
// SPI mode-0 target emulating a 23-series serial SRAM; each data byte becomes
// one Wishbone single transfer. Everything runs in clk_i; sck is only sampled.
module spi_sram_target
  import spi_sram_target_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 23,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  sck,
  input  logic                  mosi,
  input  logic                  ss_n,
  output logic                  miso,
  output logic                  miso_oe_o,
  output logic                  cyc_o,
  output logic                  stb_o,
  output logic                  we_o,
  output logic [ADDR_WIDTH-1:0] adr_o,
  output logic [7:0]            dat_o,
  input  logic [7:0]            dat_i,
  input  logic                  ack_i,
  output logic                  overrun_o
);

  logic sck_rise, sck_fall, ss_s, ss_rise, ss_fall, mosi_s;
  logic sck_s_unused, mosi_rise_unused, mosi_fall_unused;

  spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
    .clk_i, .rst_ni, .d_i(sck), .q_o(sck_s_unused), .rise_o(sck_rise), .fall_o(sck_fall));
  spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ss_sync (
    .clk_i, .rst_ni, .d_i(ss_n), .q_o(ss_s), .rise_o(ss_rise), .fall_o(ss_fall));
  spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi_sync (
    .clk_i, .rst_ni, .d_i(mosi), .q_o(mosi_s), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused));

  frame_state_t          frame_q, frame_d;
  bus_state_t            bus_q, bus_d;
  logic                  rd_mode_q, rd_mode_d;
  logic [4:0]            bit_cnt_q, bit_cnt_d;
  logic [23:0]           rx_sr_q, rx_sr_d, rx_next;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, adr_q, adr_d, req_adr;
  logic [7:0]            tx_sr_q, tx_sr_d, dat_q, dat_d, req_dat;
  logic                  tx_valid_q, tx_valid_d, miso_q, miso_d, overrun_q, overrun_d;
  logic                  rd_live_q, rd_live_d, we_q, we_d, req, req_we;

  assign rx_next = {rx_sr_q[22:0], mosi_s};

  always_comb begin
    frame_d    = frame_q;
    bus_d      = bus_q;
    rd_mode_d  = rd_mode_q;
    bit_cnt_d  = bit_cnt_q;
    rx_sr_d    = rx_sr_q;
    addr_d     = addr_q;
    tx_sr_d    = tx_sr_q;
    tx_valid_d = tx_valid_q;
    miso_d     = miso_q;
    overrun_d  = overrun_q;
    rd_live_d  = rd_live_q;
    we_d       = we_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    req        = 1'b0;
    req_we     = 1'b0;
    req_adr    = addr_q;
    req_dat    = rx_next[7:0];

    if (ss_rise) begin
      // Frame aborted: any in-flight read result becomes stale.
      frame_d    = IDLE;
      bit_cnt_d  = '0;
      miso_d     = 1'b0;
      tx_valid_d = 1'b0;
      rd_live_d  = 1'b0;
    end else begin
      case (frame_q)
        IDLE: if (ss_fall) begin
          frame_d   = CMD;
          bit_cnt_d = '0;
          overrun_d = 1'b0;
          miso_d    = 1'b0;
        end
        CMD: if (sck_rise) begin
          rx_sr_d   = rx_next;
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd7) begin
            bit_cnt_d = '0;
            rd_mode_d = (rx_next[7:0] == CMD_READ);
            if (rx_next[7:0] == CMD_READ || rx_next[7:0] == CMD_WRITE) frame_d = ADDR;
            else frame_d = IGNORE;
          end
        end
        ADDR: if (sck_rise) begin
          rx_sr_d   = rx_next;
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd23) begin
            bit_cnt_d = '0;
            addr_d    = rx_next[ADDR_WIDTH-1:0];
            if (rd_mode_q) begin
              frame_d = RDATA;
              req     = 1'b1;
              req_adr = rx_next[ADDR_WIDTH-1:0];
            end else begin
              frame_d = WDATA;
            end
          end
        end
        WDATA: if (sck_rise) begin
          rx_sr_d   = rx_next;
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd7) begin
            bit_cnt_d = '0;
            req       = 1'b1;
            req_we    = 1'b1;
            addr_d    = addr_q + 1'b1;
          end
        end
        RDATA: begin
          if (sck_rise) begin
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd7) begin
              // Host has sampled bit 0: prefetch the next sequential byte.
              bit_cnt_d  = '0;
              tx_valid_d = 1'b0;
              addr_d     = addr_q + 1'b1;
              req        = 1'b1;
              req_adr    = addr_q + 1'b1;
            end
          end else if (sck_fall && bit_cnt_q != 5'd0) begin
            // The fall with bit_cnt==0 trails the previous byte and must not shift.
            if (tx_valid_q) begin
              tx_sr_d = tx_sr_q << 1;
              miso_d  = tx_sr_q[6];
            end else begin
              miso_d = 1'b0;
              if (bit_cnt_q == 5'd1) overrun_d = 1'b1;
            end
          end
        end
        IGNORE: miso_d = 1'b0;
        default: frame_d = IDLE;
      endcase
    end

    case (bus_q)
      BUS_IDLE: if (req) begin
        bus_d     = BUS_REQ;
        we_d      = req_we;
        adr_d     = req_adr;
        rd_live_d = ~req_we;
        if (req_we) dat_d = req_dat;
      end
      BUS_REQ: begin
        if (ack_i) begin
          bus_d = BUS_IDLE;
          if (!we_q && rd_live_q && frame_q == RDATA && !ss_rise) begin
            tx_sr_d    = dat_i;
            miso_d     = dat_i[7];
            tx_valid_d = 1'b1;
          end
        end
        if (req) overrun_d = 1'b1;
      end
      default: bus_d = BUS_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      frame_q    <= IDLE;
      bus_q      <= BUS_IDLE;
      rd_mode_q  <= 1'b0;
      bit_cnt_q  <= '0;
      rx_sr_q    <= '0;
      addr_q     <= '0;
      tx_sr_q    <= '0;
      tx_valid_q <= 1'b0;
      miso_q     <= 1'b0;
      overrun_q  <= 1'b0;
      rd_live_q  <= 1'b0;
      we_q       <= 1'b0;
      adr_q      <= '0;
      dat_q      <= '0;
    end else begin
      frame_q    <= frame_d;
      bus_q      <= bus_d;
      rd_mode_q  <= rd_mode_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_sr_q    <= rx_sr_d;
      addr_q     <= addr_d;
      tx_sr_q    <= tx_sr_d;
      tx_valid_q <= tx_valid_d;
      miso_q     <= miso_d;
      overrun_q  <= overrun_d;
      rd_live_q  <= rd_live_d;
      we_q       <= we_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
    end
  end

  assign miso      = miso_q;
  assign miso_oe_o = ~ss_s;
  assign cyc_o     = (bus_q == BUS_REQ);
  assign stb_o     = (bus_q == BUS_REQ);
  assign we_o      = we_q;
  assign adr_o     = adr_q;
  assign dat_o     = dat_q;
  assign overrun_o = overrun_q;

endmodule

// File: tb/tb_spi_sram_target.sv
// Directed bench: an SPI host drives frames at sck = clk/16 while a Wishbone
// slave model acks with one cycle latency and a monitor checks each transfer.
module tb_spi_sram_target;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sck = 1'b0, mosi = 1'b0, ss_n = 1'b1;
  logic        miso, miso_oe, cyc, stb, we, overrun;
  logic [22:0] adr;
  logic [7:0]  dat_o, dat_i = 8'h00;
  logic        ack_i = 1'b0;

  int          tests_run = 0;
  int          tests_failed = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  mem [0:255];
  logic        hold_ack = 1'b0;
  logic        seen = 1'b0;
  logic        miso_or = 1'b0;

  always #5 clk = ~clk;

  spi_sram_target #(.ADDR_WIDTH(23), .SYNC_STAGES(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .sck(sck), .mosi(mosi), .ss_n(ss_n),
    .miso(miso), .miso_oe_o(miso_oe), .cyc_o(cyc), .stb_o(stb), .we_o(we),
    .adr_o(adr), .dat_o(dat_o), .dat_i(dat_i), .ack_i(ack_i), .overrun_o(overrun));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Wishbone slave model plus transfer monitor (scoreboard pop side).
  always @(negedge clk) begin
    if (!cyc) seen = 1'b0;
    if (!rst_n) begin
      ack_i = 1'b0;
    end else begin
      if (cyc && stb && !seen) begin
        seen = 1'b1;
        if (exp_q.size() == 0) begin
          check("unexpected_wb", {we, adr, we ? dat_o : 8'h00}, 32'hFFFF_FFFF);
        end else begin
          check("wb_transfer", {we, adr, we ? dat_o : 8'h00}, exp_q.pop_front());
        end
      end
      if (ack_i) begin
        ack_i = 1'b0;
      end else if (cyc && stb && !hold_ack) begin
        ack_i = 1'b1;
        if (we) mem[adr[7:0]] = dat_o;
        else dat_i = mem[adr[7:0]];
      end
    end
  end

  task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      mosi = tx[i];
      repeat (8) @(negedge clk);
      sck = 1'b1;
      rx[i] = miso;
      miso_or = miso_or | miso;
      repeat (8) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] b);
    logic [7:0] rx;
    spi_xfer(b, 8, rx);
  endtask

  task automatic frame_begin();
    ss_n = 1'b0;
    miso_or = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic frame_end();
    repeat (8) @(negedge clk);
    ss_n = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic drain(input string name);
    repeat (10) @(negedge clk);
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    logic [7:0] rx;
    int         waited;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_miso", {31'd0, miso}, 0);
    check("rst_oe", {31'd0, miso_oe}, 0);
    check("rst_cyc_stb_we", {29'd0, cyc, stb, we}, 0);
    check("rst_adr_dat", {1'b0, adr, dat_o}, 0);
    check("rst_overrun", {31'd0, overrun}, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single write
    exp_q.push_back({1'b1, 23'h000120, 8'hA5});
    frame_begin();
    check("oe_in_frame", {31'd0, miso_oe}, 1);
    send(8'h02); send(8'h00); send(8'h01); send(8'h20); send(8'hA5);
    frame_end();
    check("oe_after_frame", {31'd0, miso_oe}, 0);
    drain("single_write_done");
    check("single_write_overrun", {31'd0, overrun}, 0);

    // Burst write crossing 0xFF -> 0x100
    exp_q.push_back({1'b1, 23'h0000FF, 8'h11});
    exp_q.push_back({1'b1, 23'h000100, 8'h22});
    exp_q.push_back({1'b1, 23'h000101, 8'h33});
    frame_begin();
    send(8'h02); send(8'h00); send(8'h00); send(8'hFF);
    send(8'h11); send(8'h22); send(8'h33);
    frame_end();
    drain("burst_write_done");

    // Sequential read with prefetch of the byte after the last one clocked out
    mem[8'h10] = 8'h3C;
    mem[8'h11] = 8'hC3;
    mem[8'h12] = 8'h5A;
    exp_q.push_back({1'b0, 23'h000010, 8'h00});
    exp_q.push_back({1'b0, 23'h000011, 8'h00});
    exp_q.push_back({1'b0, 23'h000012, 8'h00});
    frame_begin();
    send(8'h03); send(8'h00); send(8'h00); send(8'h10);
    spi_xfer(8'h00, 8, rx);
    check("read_byte0", {24'd0, rx}, 32'h3C);
    spi_xfer(8'h00, 8, rx);
    check("read_byte1", {24'd0, rx}, 32'hC3);
    frame_end();
    drain("read_done");
    check("read_overrun", {31'd0, overrun}, 0);

    // Address wrap at the top of the 23-bit space
    exp_q.push_back({1'b1, 23'h7FFFFF, 8'hAA});
    exp_q.push_back({1'b1, 23'h000000, 8'hBB});
    frame_begin();
    send(8'h02); send(8'h7F); send(8'hFF); send(8'hFF); send(8'hAA); send(8'hBB);
    frame_end();
    drain("wrap_done");

    // Unknown command: no bus activity, miso stays low; then a valid write
    frame_begin();
    send(8'h9F);
    for (int i = 0; i < 4; i++) begin
      spi_xfer(8'hFF, 8, rx);
    end
    frame_end();
    check("ignore_miso_low", {31'd0, miso_or}, 0);
    drain("ignore_no_wb");
    exp_q.push_back({1'b1, 23'h000033, 8'h5E});
    frame_begin();
    send(8'h02); send(8'h00); send(8'h00); send(8'h33); send(8'h5E);
    frame_end();
    drain("after_ignore_write");

    // Partial data byte discarded
    frame_begin();
    send(8'h02); send(8'h00); send(8'h00); send(8'h40);
    spi_xfer(8'hF0, 4, rx);
    frame_end();
    drain("partial_no_wb");

    // Overrun: second byte completes while first write is still unacked
    hold_ack = 1'b1;
    exp_q.push_back({1'b1, 23'h000050, 8'h01});
    frame_begin();
    send(8'h02); send(8'h00); send(8'h00); send(8'h50); send(8'h01); send(8'h02);
    frame_end();
    check("overrun_set", {31'd0, overrun}, 1);
    hold_ack = 1'b0;
    drain("overrun_first_only");
    exp_q.push_back({1'b1, 23'h000060, 8'h77});
    frame_begin();
    check("overrun_cleared", {31'd0, overrun}, 0);
    send(8'h02); send(8'h00); send(8'h00); send(8'h60); send(8'h77);
    frame_end();
    drain("post_overrun_write");

    // Reset while a transfer is held in BUS_REQ
    hold_ack = 1'b1;
    exp_q.push_back({1'b1, 23'h000070, 8'h99});
    frame_begin();
    send(8'h02); send(8'h00); send(8'h00); send(8'h70); send(8'h99);
    frame_end();
    waited = 0;
    while (!cyc && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("cyc_before_reset", {31'd0, cyc}, 1);
    rst_n = 1'b0;
    #1;
    check("reset_cyc_stb", {30'd0, cyc, stb}, 0);
    check("reset_bus_outputs", {we, adr, dat_o}, 0);
    repeat (3) @(negedge clk);
    hold_ack = 1'b0;
    rst_n = 1'b1;
    drain("reset_queue_empty");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
